// File: rtl/trig_pulse_generator_pkg.sv
// Shared types and constants for the trigger pulse generator.
package trig_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int unsigned MIN_PERIOD = 2;
    localparam int unsigned MIN_WIDTH  = 1;

    localparam int unsigned RST_PERIOD = 2;
    localparam int unsigned RST_WIDTH  = 1;
    localparam int unsigned RST_BURST  = 0;

endpackage

// File: rtl/trig_pulse_generator_if.sv
// Control/status bundle of the trigger pulse generator.
interface trig_pulse_generator_if #(
    parameter int CNT_W   = 16,
    parameter int WID_W   = 8,
    parameter int BURST_W = 16
);
    logic               enable;
    logic               start;
    logic [CNT_W-1:0]   period;
    logic [WID_W-1:0]   width;
    logic [BURST_W-1:0] burst_len;
    logic               ext_trig;
    logic               pulse;
    logic               busy;
    logic               done;
    logic [BURST_W-1:0] pulse_cnt;

    modport master (
        output enable, start, period, width, burst_len, ext_trig,
        input  pulse, busy, done, pulse_cnt
    );

    modport slave (
        input  enable, start, period, width, burst_len, ext_trig,
        output pulse, busy, done, pulse_cnt
    );
endinterface

// File: rtl/trig_pulse_generator_sync.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);
    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1   <= async_in;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
        end
    end
endmodule

// File: rtl/trig_pulse_generator.sv
// Periodic/burst trigger pulse generator with shadowed settings.
// Optional external arm trigger: define TRIG_PULSE_GEN_EXT_TRIG_EN.
module trig_pulse_generator
    import trig_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int WID_W   = 8,
    parameter int BURST_W = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    trig_pulse_generator_if.slave bus
);
    localparam int CW = (CNT_W > WID_W) ? CNT_W : WID_W;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   period_l, period_l_nxt;
    logic [CNT_W-1:0]   width_l, width_l_nxt;
    logic [BURST_W-1:0] burst_l, burst_l_nxt;
    logic [CNT_W-1:0]   phase, phase_nxt;
    logic [BURST_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic               pulse_q, pulse_nxt;
    logic               done_q, done_nxt;
    logic [CNT_W-1:0]   period_c;
    logic [CW-1:0]      width_c;

`ifdef TRIG_PULSE_GEN_EXT_TRIG_EN
    logic trig_rise;

    sync_edge_det u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (bus.ext_trig),
        .rise     (trig_rise)
    );
`endif

    // Width is clamped against the already-clamped period, in a common width.
    always_comb begin
        period_c = (bus.period < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : bus.period;
        width_c  = CW'(bus.width);
        if (width_c < CW'(MIN_WIDTH))
            width_c = CW'(MIN_WIDTH);
        if (width_c > CW'(period_c) - CW'(1))
            width_c = CW'(period_c) - CW'(1);
    end

    assign cnt_inc = (cnt == '1) ? cnt : cnt + BURST_W'(1);

    always_comb begin
        state_nxt    = state;
        period_l_nxt = period_l;
        width_l_nxt  = width_l;
        burst_l_nxt  = burst_l;
        phase_nxt    = phase;
        cnt_nxt      = cnt;
        pulse_nxt    = 1'b0;
        done_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (bus.start && bus.enable) begin
                    period_l_nxt = period_c;
                    width_l_nxt  = CNT_W'(width_c);
                    burst_l_nxt  = bus.burst_len;
                    phase_nxt    = '0;
`ifdef TRIG_PULSE_GEN_EXT_TRIG_EN
                    state_nxt    = ARMED;
                    cnt_nxt      = '0;
`else
                    // Phase 0 starts on this edge, so the first pulse is counted here.
                    state_nxt    = RUN;
                    cnt_nxt      = BURST_W'(1);
                    pulse_nxt    = 1'b1;
`endif
                end
            end

            ARMED: begin
                if (!bus.enable)
                    state_nxt = IDLE;
`ifdef TRIG_PULSE_GEN_EXT_TRIG_EN
                else if (trig_rise) begin
                    state_nxt = RUN;
                    phase_nxt = '0;
                    cnt_nxt   = cnt_inc;
                    pulse_nxt = 1'b1;
                end
`endif
            end

            RUN: begin
                if (!bus.enable) begin
                    state_nxt = IDLE;
                end else if (phase == period_l - CNT_W'(1)) begin
                    if (burst_l != '0 && cnt >= burst_l) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        phase_nxt = '0;
                        cnt_nxt   = cnt_inc;
                        pulse_nxt = 1'b1;
                    end
                end else begin
                    phase_nxt = phase + CNT_W'(1);
                    pulse_nxt = (phase + CNT_W'(1)) < width_l;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            period_l <= CNT_W'(RST_PERIOD);
            width_l  <= CNT_W'(RST_WIDTH);
            burst_l  <= BURST_W'(RST_BURST);
            phase    <= '0;
            cnt      <= '0;
            pulse_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            period_l <= period_l_nxt;
            width_l  <= width_l_nxt;
            burst_l  <= burst_l_nxt;
            phase    <= phase_nxt;
            cnt      <= cnt_nxt;
            pulse_q  <= pulse_nxt;
            done_q   <= done_nxt;
        end
    end

    assign bus.pulse     = pulse_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.pulse_cnt = cnt;
endmodule

// File: doc/trig_pulse_generator.md
TRIG_PULSE_GENERATOR -- requirements
Module: trig_pulse_generator

Interface
REQ-001 Parameter CNT_W, default 16: width of the period and phase counters.
REQ-002 Parameter WID_W, default 8: width of the pulse-width input.
REQ-003 Parameter BURST_W, default 16: width of the burst length and pulse count.
REQ-004 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 Port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 Port enable, input, 1: generator enable; low aborts a run.
REQ-007 Port start, input, 1: one-cycle request to begin a run.
REQ-008 Port period, input, CNT_W: pulse period in clk cycles.
REQ-009 Port width, input, WID_W: pulse high time in clk cycles.
REQ-010 Port burst_len, input, BURST_W: number of pulses per run; 0 means continuous.
REQ-011 Port ext_trig, input, 1: asynchronous external arm trigger, used only with EXT_TRIG_EN.
REQ-012 Port pulse, output, 1: registered trigger pulse that feeds the delay generator pulse input.
REQ-013 Port busy, output, 1: high while a run is armed or in progress.
REQ-014 Port done, output, 1: one-cycle strobe when a burst completes normally.
REQ-015 Port pulse_cnt, output, BURST_W: number of pulses issued in the current or most recent run.

Function
REQ-016 The block SHALL use FSM states IDLE, ARMED and RUN; ARMED is reachable only with EXT_TRIG_EN.
REQ-017 In IDLE, start=1 with enable=1 SHALL latch period, width and burst_len into shadow registers, clear pulse_cnt and the phase counter, and go to RUN (or ARMED).
REQ-018 In IDLE, start=1 with enable=0 SHALL be ignored.
REQ-019 In ARMED or RUN, start SHALL be ignored, and input changes SHALL NOT affect the shadow values.
REQ-020 Shadow period SHALL be clamped to a minimum of 2.
REQ-021 Shadow width SHALL be clamped to the range 1 to period_l-1, using the already-clamped period.
REQ-022 In RUN, the phase counter SHALL count 0 to period_l-1 and then wrap to 0.
REQ-023 pulse SHALL be high exactly while the phase is less than width_l, registered so it has no glitches.
REQ-024 Latency: with start sampled in cycle N (no EXT_TRIG_EN), pulse SHALL rise in cycle N+1.
REQ-025 pulse_cnt SHALL increment in the same cycle pulse rises, saturating at its maximum value.
REQ-026 With burst_len_l > 0, after pulse number burst_len_l the period SHALL run to completion, the FSM SHALL return to IDLE, and done SHALL be 1 for exactly one cycle at that transition.
REQ-027 With burst_len_l = 0, the run SHALL continue until enable goes low.
REQ-028 enable=0 in ARMED or RUN SHALL force IDLE and pulse=0 on the next edge, with no done strobe.
REQ-029 pulse_cnt SHALL hold its value after an abort or after done.
REQ-030 busy SHALL be 1 in ARMED and RUN and 0 in IDLE.

Reset
REQ-031 rst_n=0 on a clock edge SHALL force: state IDLE, pulse 0, busy 0, done 0, pulse_cnt 0, counters 0, and shadows to period 2, width 1, burst 0.
REQ-032 Reset mid-run SHALL take priority over every other input in that cycle.

Configuration
REQ-033 Macro TRIG_PULSE_GEN_EXT_TRIG_EN, when defined, SHALL pass ext_trig through a 2-flop synchronizer and a rising-edge detector.
REQ-034 With that macro defined, start SHALL go to ARMED, and the first detected ext_trig rising edge SHALL move the FSM to RUN with phase 0, so pulse rises 4 cycles after the ext_trig edge.
REQ-035 With that macro undefined, ext_trig SHALL be unused, ARMED SHALL be unreachable, and start SHALL go directly to RUN.

Structure
REQ-036 Package trig_pkg SHALL hold the FSM state typedef, the constants MIN_PERIOD=2 and MIN_WIDTH=1, and the reset shadow values.
REQ-037 The synchronizer and edge detector SHALL be sub-module sync_edge_det (input async_in; output rise), instantiated only under the macro.

Verification
REQ-038 period=10, width=3, burst_len=4, start in cycle 5: pulse high cycles 6-8, 16-18, 26-28, 36-38; done in cycle 46; pulse_cnt=4.
REQ-039 period=1, width=0: clamped to period 2, width 1; pulse alternates 1,0; burst_len=0 runs until enable drops.
REQ-040 period=5, width=9: width clamped to 4; pulse high 4 cycles, low 1 cycle.
REQ-041 burst_len=0, enable dropped after 3 pulses: pulse 0 next cycle, busy 0, no done, pulse_cnt=3; a second start while running is ignored.
REQ-042 rst_n=0 in the middle of a pulse: all outputs are at reset values on the next edge, and a fresh start resumes normally.
REQ-043 With the macro defined, start then ext_trig rising at cycle 20: busy is 1 from start, and pulse first rises in cycle 24.
